// File: rtl/btn_bcd_accum.sv
// Packed-BCD running total driven by debounced buttons: button i adds 10^i.
// Rising edges queue per-button requests; a two-state FSM ripples one increment at a time.
module btn_bcd_accum #(
   parameter int NDIG = 8,
   parameter int NBTN = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NBTN-1:0]     btn,
   input  logic                clr,
   input  logic                ld,
   input  logic [4*NDIG-1:0]   ld_val,
   output logic [4*NDIG-1:0]   num,
   output logic                busy,
   output logic                ovf
);

   localparam int PW = (NDIG > 1) ? $clog2(NDIG) : 1;

   typedef enum logic {
      S_IDLE,
      S_ADD
   } state_t;

   state_t              state_q, state_d;
   logic [PW-1:0]       ptr_q, ptr_d;
   logic [NBTN-1:0]     pend_q, pend_d;
   logic [NBTN-1:0]     btn_q, btn_d;
   logic [4*NDIG-1:0]   num_q, num_d;
   logic                ovf_q, ovf_d;

   logic [NBTN-1:0]     btn_rise;
   logic [NBTN-1:0]     take_mask;
   logic [PW-1:0]       sel;
   logic                found;
   logic [3:0]          digit;

   always_comb begin
      btn_rise  = btn & ~btn_q;
      state_d   = state_q;
      ptr_d     = ptr_q;
      btn_d     = btn;
      num_d     = num_q;
      ovf_d     = ovf_q;
      take_mask = '0;
      digit     = num_q[{ptr_q, 2'b00} +: 4];

      // Descending scan so the lowest pending index is the one left in sel.
      sel   = '0;
      found = 1'b0;
      for (int i = NBTN - 1; i >= 0; i--) begin
         if (pend_q[i]) begin
            sel   = PW'(i);
            found = 1'b1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (found) begin
               take_mask = NBTN'(1) << sel;
               ptr_d     = sel;
               state_d   = S_ADD;
            end
         end
         S_ADD: begin
            // Anything 9 or above (including non-BCD A-F) wraps to 0 and carries.
            if (digit >= 4'd9) begin
               num_d[{ptr_q, 2'b00} +: 4] = 4'd0;
               if (ptr_q == PW'(NDIG - 1)) begin
                  ovf_d   = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  ptr_d = ptr_q + PW'(1);
               end
            end else begin
               num_d[{ptr_q, 2'b00} +: 4] = digit + 4'd1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A fresh edge on the bit being taken keeps it pending.
      pend_d = (pend_q & ~take_mask) | btn_rise;

      if (clr) begin
         num_d   = '0;
         pend_d  = '0;
         ovf_d   = 1'b0;
         state_d = S_IDLE;
      end else if (ld) begin
         num_d   = ld_val;
         pend_d  = '0;
         ovf_d   = 1'b0;
         state_d = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         pend_q  <= '0;
         btn_q   <= '0;
         num_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         pend_q  <= pend_d;
         btn_q   <= btn_d;
         num_q   <= num_d;
         ovf_q   <= ovf_d;
      end
   end

   assign num  = num_q;
   assign ovf  = ovf_q;
   assign busy = (state_q != S_IDLE) | (|pend_q);

endmodule

// File: tb/tb_btn_bcd_accum.sv
// Randomized and directed bench for btn_bcd_accum against a decimal-arithmetic model.
module tb_btn_bcd_accum;

   localparam int NDIG = 8;
   localparam int NBTN = 5;

   logic                clk;
   logic                rst_n;
   logic [NBTN-1:0]     btn;
   logic                clr;
   logic                ld;
   logic [4*NDIG-1:0]   ld_val;
   logic [4*NDIG-1:0]   num;
   logic                busy;
   logic                ovf;

   int                  n_chk;
   int                  n_bad;

   // Model state: the settled total as a plain integer and the sticky wrap flag.
   int unsigned         m_total;
   bit                  m_ovf;

   btn_bcd_accum #(.NDIG(NDIG), .NBTN(NBTN)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn    (btn),
      .clr    (clr),
      .ld     (ld),
      .ld_val (ld_val),
      .num    (num),
      .busy   (busy),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int unsigned pow10(input int e);
      int unsigned r;
      r = 1;
      for (int j = 0; j < e; j++) r = r * 10;
      return r;
   endfunction

   function automatic int dig(input int unsigned v, input int j);
      return int'((v / pow10(j)) % 10);
   endfunction

   function automatic logic [4*NDIG-1:0] to_bcd(input int unsigned v);
      logic [4*NDIG-1:0] r;
      r = '0;
      for (int j = 0; j < NDIG; j++) r[4*j +: 4] = 4'(dig(v, j));
      return r;
   endfunction

   // Digits touched when adding 10^i to v: the digit itself plus every 9 it carries through.
   function automatic int touched(input int unsigned v, input int i);
      int k;
      int j;
      k = 1;
      j = i;
      while (dig(v, j) == 9 && j < NDIG - 1) begin
         j++;
         k++;
      end
      return k;
   endfunction

   task automatic model_add(input int i);
      m_total = m_total + pow10(i);
      if (m_total >= pow10(NDIG)) begin
         m_total = m_total - pow10(NDIG);
         m_ovf   = 1'b1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_ld(input int unsigned v);
      ld_val = to_bcd(v);
      ld     = 1'b1;
      tick();
      ld      = 1'b0;
      m_total = v;
      m_ovf   = 1'b0;
      chk("ld_num", num, to_bcd(m_total));
      chk("ld_ovf", ovf, m_ovf);
      chk("ld_busy", busy, 1'b0);
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr     = 1'b0;
      m_total = 0;
      m_ovf   = 1'b0;
      chk("clr_num", num, '0);
      chk("clr_ovf", ovf, 1'b0);
      chk("clr_busy", busy, 1'b0);
   endtask

   // Raise mask from an all-low state, hold it for `hold` cycles, and check the
   // busy duration (sum of 1+k per increment, lowest button first) and the result.
   task automatic run_press(input string tag, input logic [NBTN-1:0] mask, input int hold);
      int  exp_cyc;
      int  cnt;
      int  c;
      bit  done;
      bit  quiet;
      exp_cyc = 0;
      for (int i = 0; i < NBTN; i++) begin
         if (mask[i]) begin
            exp_cyc += 1 + touched(m_total, i);
            model_add(i);
         end
      end
      btn  = mask;
      cnt  = 0;
      c    = 0;
      done = 1'b0;
      while (!done && c < 300) begin
         tick();
         c++;
         if (c == hold) btn = '0;
         if (busy) cnt++;
         else if (cnt > 0) done = 1'b1;
      end
      quiet = 1'b1;
      while (c < hold) begin
         tick();
         c++;
         if (busy) quiet = 1'b0;
      end
      btn = '0;
      tick();
      tick();
      if (busy) quiet = 1'b0;
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_busy_cycles"}, cnt, exp_cyc);
      chk({tag, "_no_retrigger"}, quiet, 1'b1);
      chk({tag, "_num"}, num, to_bcd(m_total));
      chk({tag, "_ovf"}, ovf, m_ovf);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned v;
      int          r;
      n_chk   = 0;
      n_bad   = 0;
      m_total = 0;
      m_ovf   = 1'b0;
      rst_n   = 1'b0;
      btn     = '0;
      clr     = 1'b0;
      ld      = 1'b0;
      ld_val  = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      chk("rst_num", num, '0);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_busy", busy, 1'b0);

      // Single-cycle pulse: result must appear exactly two edges after the sample.
      btn = 5'b00001;
      tick();
      btn = '0;
      chk("pulse_busy_e0", busy, 1'b1);
      chk("pulse_num_e0", num, '0);
      tick();
      chk("pulse_num_e1", num, '0);
      tick();
      chk("pulse_num_e2", num, to_bcd(1));
      chk("pulse_busy_e2", busy, 1'b0);
      m_total = 1;

      do_clr();
      run_press("hold100", 5'b01000, 100);
      chk("hold100_val", num, 32'h0000_1000);
      run_press("repress", 5'b01000, 3);
      chk("repress_val", num, 32'h0000_2000);

      do_ld(9999);
      run_press("carry4", 5'b00001, 1);
      chk("carry4_val", num, 32'h0001_0000);

      do_clr();
      run_press("dual", 5'b01001, 2);
      chk("dual_val", num, 32'h0000_1001);

      do_ld(99999999);
      run_press("wrap", 5'b00001, 1);
      chk("wrap_val", num, 32'h0000_0000);
      chk("wrap_ovf", ovf, 1'b1);
      run_press("sticky", 5'b00100, 1);
      chk("sticky_ovf", ovf, 1'b1);
      do_clr();

      // clr during the second ADD of a carry chain.
      do_ld(999);
      btn = 5'b00001;
      tick();
      btn = '0;
      tick();
      tick();
      chk("midclr_inter", num, 32'h0000_0990);
      chk("midclr_busy_pre", busy, 1'b1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      chk("midclr_num", num, '0);
      chk("midclr_busy", busy, 1'b0);
      tick();
      chk("midclr_stays", num, '0);
      chk("midclr_idle", busy, 1'b0);
      m_total = 0;
      m_ovf   = 1'b0;

      // Asynchronous reset during the same carry chain.
      do_ld(999);
      btn = 5'b00001;
      tick();
      btn = '0;
      tick();
      tick();
      chk("midrst_inter", num, 32'h0000_0990);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_num", num, '0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_ovf", ovf, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      tick();
      tick();
      chk("midrst_after", num, '0);
      chk("midrst_idle", busy, 1'b0);
      m_total = 0;
      m_ovf   = 1'b0;

      // Randomized mix of loads, clears and button patterns biased towards carries.
      for (int it = 0; it < 60; it++) begin
         r = int'($urandom_range(0, 99));
         if (r < 15) begin
            v = 0;
            for (int j = 0; j < NDIG; j++) begin
               if ($urandom_range(0, 9) < 6) v = v + 9 * pow10(j);
               else v = v + $urandom_range(0, 8) * pow10(j);
            end
            do_ld(v);
         end else if (r < 20) begin
            do_clr();
         end else begin
            run_press("rnd", NBTN'($urandom_range(1, 31)), int'($urandom_range(1, 8)));
         end
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
